// File: rtl/garduino_adc_spi_reader_if.sv
// Avalon-MM slave bus bundle between the Nios host and the ADC reader.
// Latency: none, this file only groups wires.
// Backpressure: none; the Avalon slave has no wait states.
interface garduino_adc_spi_reader_if;
   logic [3:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/garduino_adc_spi_reader.sv
// Scans an ADC128S022-class serial ADC and holds the latest 12-bit code per channel.
// Latency: 35*CLK_DIV clk cycles per frame, NUM_CH+1 frames per sweep; reads are combinational.
// Backpressure: none. A START written while busy is ignored. Optional irq output under `ADC_IRQ_EN.
module garduino_adc_spi_reader #(
   parameter int CLK_DIV = 25,
   parameter int NUM_CH  = 8
) (
   input  logic clk,
   input  logic reset_n,
   garduino_adc_spi_reader_if.slave bus,
   output logic adc_cs_n,
   output logic adc_sclk,
   output logic adc_din,
   input  logic adc_dout
`ifdef ADC_IRQ_EN
   ,
   output logic irq
`endif
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [3:0] NUM_CH_W = 4'(NUM_CH);

   logic [2:0]  state;
   logic [7:0]  cnt;
   logic [4:0]  hcnt;
   logic [3:0]  k;
   logic [15:0] sr;
   logic        dout_s1, dout_s2;
   logic        ctrl_cont, ctrl_irq_en;
   logic        done;
   logic [7:0]  sweep_cnt;
   logic [11:0] res_code [NUM_CH];
   logic        res_vld  [NUM_CH];

   logic        wr, start_wr, done_clr, cnt_end, sweep_end, store;
   logic [2:0]  ch;
   logic [15:0] frame_word;

   assign wr        = bus.chipselect && !bus.write_n;
   assign start_wr  = wr && (bus.address == 4'd0) && bus.writedata[1];
   assign done_clr  = wr && (bus.address == 4'd1) && bus.writedata[1];
   assign cnt_end   = (cnt == DIV_LAST);
   assign sweep_end = (state == ST_GAP) && cnt_end && (k == NUM_CH_W);
   // The final frame (k == NUM_CH) readdresses channel 0 only to flush the pipeline.
   assign ch         = (k == NUM_CH_W) ? 3'd0 : k[2:0];
   assign frame_word = {2'b00, ch, 11'd0};
   // Frame 0 returns a stale conversion, so frame k lands in slot k-1.
   assign store = (state == ST_SHIFT) && cnt_end && (hcnt == 5'd31) && (k != 4'd0);

   logic unused_ok;
   assign unused_ok = ^{bus.writedata[31:3], sr[15:12]};

   // Two-flop synchroniser for the ADC data line.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout_s1 <= 1'b0;
         dout_s2 <= 1'b0;
      end else begin
         dout_s1 <= adc_dout;
         dout_s2 <= dout_s1;
      end
   end

   // Host-writable control bits; START is not stored, it only launches a sweep.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_cont   <= 1'b0;
         ctrl_irq_en <= 1'b0;
      end else if (wr && bus.address == 4'd0) begin
         ctrl_cont   <= bus.writedata[0];
         ctrl_irq_en <= bus.writedata[2];
      end
   end

   // Frame sequencer: drives cs_n/sclk/din and shifts in dout on rising sclk.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         cnt       <= 8'd0;
         hcnt      <= 5'd0;
         k         <= 4'd0;
         sr        <= 16'd0;
         adc_cs_n  <= 1'b1;
         adc_sclk  <= 1'b1;
         adc_din   <= 1'b0;
         sweep_cnt <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_wr || ctrl_cont) begin
                  state    <= ST_SETUP;
                  adc_cs_n <= 1'b0;
                  k        <= 4'd0;
                  cnt      <= 8'd0;
               end
            end
            ST_SETUP: begin
               if (cnt_end) begin
                  state    <= ST_SHIFT;
                  cnt      <= 8'd0;
                  hcnt     <= 5'd0;
                  adc_sclk <= 1'b0;
                  adc_din  <= frame_word[15];
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_SHIFT: begin
               if (cnt_end) begin
                  cnt  <= 8'd0;
                  hcnt <= hcnt + 5'd1;
                  if (!hcnt[0]) begin
                     adc_sclk <= 1'b1;
                     sr       <= {sr[14:0], dout_s2};
                  end else if (hcnt == 5'd31) begin
                     state <= ST_HOLD;
                  end else begin
                     adc_sclk <= 1'b0;
                     adc_din  <= frame_word[4'd14 - hcnt[4:1]];
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_HOLD: begin
               if (cnt_end) begin
                  state    <= ST_GAP;
                  cnt      <= 8'd0;
                  adc_cs_n <= 1'b1;
                  adc_din  <= 1'b0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_GAP: begin
               if (cnt_end) begin
                  cnt <= 8'd0;
                  if (k != NUM_CH_W) begin
                     k        <= k + 4'd1;
                     state    <= ST_SETUP;
                     adc_cs_n <= 1'b0;
                  end else begin
                     sweep_cnt <= sweep_cnt + 8'd1;
                     if (ctrl_cont) begin
                        k        <= 4'd0;
                        state    <= ST_SETUP;
                        adc_cs_n <= 1'b0;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Result registers update whole on HOLD entry so reads never see a partial code.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int n = 0; n < NUM_CH; n++) begin
            res_code[n] <= 12'd0;
            res_vld[n]  <= 1'b0;
         end
      end else if (store) begin
         for (int n = 0; n < NUM_CH; n++) begin
            if (k == 4'(n + 1)) begin
               res_code[n] <= sr[11:0];
               res_vld[n]  <= 1'b1;
            end
         end
      end
   end

   // Sticky DONE; a sweep completing in the same cycle as a host clear keeps it set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done <= 1'b0;
      end else if (sweep_end) begin
         done <= 1'b1;
      end else if (done_clr) begin
         done <= 1'b0;
      end
   end

`ifdef ADC_IRQ_EN
   // Registered interrupt, one cycle behind DONE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq <= 1'b0;
      end else begin
         irq <= done && ctrl_irq_en;
      end
   end
`endif

   // Combinational read mux; unmapped words read zero.
   always_comb begin
      bus.readdata = 32'd0;
      case (bus.address)
         4'd0: bus.readdata = {29'd0, ctrl_irq_en, 1'b0, ctrl_cont};
         4'd1: bus.readdata = {16'd0, sweep_cnt, 6'd0, done, (state != ST_IDLE)};
         default: begin
            for (int n = 0; n < NUM_CH; n++) begin
               if (bus.address == 4'(8 + n)) begin
                  bus.readdata = {res_vld[n], 19'd0, res_code[n]};
               end
            end
         end
      endcase
   end

endmodule

// File: tb/tb_garduino_adc_spi_reader.sv
// Directed bench for garduino_adc_spi_reader with a behavioural ADC128S022 model.
// Latency: frame = 35*CLK_DIV = 140 clk, sweep = 9 frames = 1260 clk with CLK_DIV=4.
// Backpressure: none; every wait on the DUT is bounded by a cycle budget.
module tb_garduino_adc_spi_reader;

   localparam int CLK_DIV = 4;
   localparam int NUM_CH  = 8;
   localparam int FRAME   = 35 * CLK_DIV;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic adc_cs_n, adc_sclk, adc_din;
   logic adc_dout = 1'b0;
`ifdef ADC_IRQ_EN
   logic irq;
`endif

   garduino_adc_spi_reader_if bus_if ();

   garduino_adc_spi_reader #(.CLK_DIV(CLK_DIV), .NUM_CH(NUM_CH)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus_if),
      .adc_cs_n (adc_cs_n),
      .adc_sclk (adc_sclk),
      .adc_din  (adc_din),
      .adc_dout (adc_dout)
`ifdef ADC_IRQ_EN
      ,
      .irq      (irq)
`endif
   );

   always #5 clk = ~clk;

   int vec_cnt = 0;
   int err_cnt = 0;

   // ADC model: returns 0x100+addr of the channel addressed in the previous frame.
   logic [2:0]  adc_addr_prev = 3'd0;
   logic [15:0] out_word = 16'd0;
   logic [15:0] din_cap = 16'd0;
   int          fall_cnt = 0;
   int          rise_cnt = 0;
   int          low_cyc = 0;
   int          q_low[$];
   int          q_rise[$];
   logic [15:0] q_din[$];

   always @(negedge adc_cs_n) begin
      fall_cnt = 0;
      rise_cnt = 0;
      out_word = {4'h0, 12'h100 + {9'd0, adc_addr_prev}};
   end

   always @(posedge adc_cs_n) begin
      adc_addr_prev = din_cap[13:11];
   end

   always @(negedge adc_sclk) begin
      if (!adc_cs_n && fall_cnt < 16) begin
         adc_dout = out_word[15 - fall_cnt];
         fall_cnt++;
      end
   end

   always @(posedge adc_sclk) begin
      if (!adc_cs_n) begin
         din_cap = {din_cap[14:0], adc_din};
         rise_cnt++;
      end
   end

   // Log each cs_n low pulse: its length in clk cycles, rising sclk count and din word.
   always @(posedge clk) begin
      if (!adc_cs_n) begin
         low_cyc++;
      end else if (low_cyc != 0) begin
         q_low.push_back(low_cyc);
         q_rise.push_back(rise_cnt);
         q_din.push_back(din_cap);
         low_cyc = 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      bus_if.address    = a;
      bus_if.writedata  = d;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b0;
      @(negedge clk);
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      bus_if.address = a;
      #1 d = bus_if.readdata;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      logic [31:0] d;
      int n;
      n = 0;
      do begin
         rd(4'd1, d);
         n++;
      end while (d[0] && n < budget);
      chk(tag, {31'd0, d[0]}, 32'd0);
   endtask

   task automatic clear_log();
      q_low.delete();
      q_rise.delete();
      q_din.delete();
   endtask

   logic [31:0] d;

   initial begin
      bus_if.address    = 4'd0;
      bus_if.writedata  = 32'd0;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_cs_n", {31'd0, adc_cs_n}, 32'd1);
      chk("rst_sclk", {31'd0, adc_sclk}, 32'd1);
      chk("rst_din",  {31'd0, adc_din},  32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      rd(4'd0, d); chk("rst_ctrl", d, 32'd0);
      rd(4'd1, d); chk("rst_status", d, 32'd0);
      rd(4'd8, d); chk("rst_result0", d, 32'd0);
      clear_log();

      // Single sweep, with a START written mid-sweep that must be ignored.
      wr(4'd0, 32'h2);
      rd(4'd1, d); chk("busy_after_start", d & 32'h1, 32'h1);
      repeat (300) @(negedge clk);
      wr(4'd0, 32'h2);
      wait_idle(3000, "sweep1_timeout");
      chk("sweep1_frames", q_low.size(), 32'd9);
      for (int i = 0; i < q_low.size(); i++) begin
         chk($sformatf("f%0d_cs_low", i), q_low[i], 32'd136);
         chk($sformatf("f%0d_rises", i), q_rise[i], 32'd16);
         chk($sformatf("f%0d_din", i), {16'd0, q_din[i]}, 32'((i % 8) << 11));
      end
      for (int n = 0; n < NUM_CH; n++) begin
         rd(4'(8 + n), d);
         chk($sformatf("result%0d", n), d, 32'h8000_0100 + 32'(n));
      end
      rd(4'd1, d); chk("status_sweep1", d, 32'h0000_0102);
      rd(4'd0, d); chk("ctrl_start_reads0", d, 32'd0);
      rd(4'd7, d); chk("unmapped_7", d, 32'd0);
      chk("idle_cs_n", {31'd0, adc_cs_n}, 32'd1);
      chk("idle_sclk", {31'd0, adc_sclk}, 32'd1);
`ifdef ADC_IRQ_EN
      chk("irq_disabled", {31'd0, irq}, 32'd0);
`endif

      // Clearing DONE, then a clear that lands in the same cycle DONE sets.
      wr(4'd1, 32'h2);
      rd(4'd1, d); chk("done_cleared", d, 32'h0000_0100);
      wr(4'd0, 32'h2);
      repeat (9 * FRAME - 2) @(negedge clk);
      wr(4'd1, 32'h2);
      rd(4'd1, d); chk("done_set_wins", d, 32'h0000_0202);
      wr(4'd1, 32'h2);
      rd(4'd1, d); chk("done_clear2", d, 32'h0000_0200);

      // Continuous sweeps; clearing CONT mid-sweep lets the fourth sweep finish.
      clear_log();
      wr(4'd0, 32'h1);
      repeat (3 * 9 * FRAME + 100) @(negedge clk);
      wr(4'd0, 32'h0);
      wait_idle(3000, "cont_timeout");
      rd(4'd1, d); chk("cont_sweep_cnt", d & 32'hFF01, 32'h0000_0600);
      chk("cont_frames", q_low.size(), 32'd36);
      chk("cont_cs_n_idle", {31'd0, adc_cs_n}, 32'd1);

      // Asynchronous reset in the middle of frame 3.
      wr(4'd0, 32'h2);
      repeat (3 * FRAME + 60) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_cs_n", {31'd0, adc_cs_n}, 32'd1);
      chk("arst_sclk", {31'd0, adc_sclk}, 32'd1);
      bus_if.address = 4'd8;
      #1 chk("arst_result0", bus_if.readdata, 32'd0);
      bus_if.address = 4'd15;
      #1 chk("arst_result7", bus_if.readdata, 32'd0);
      bus_if.address = 4'd1;
      #1 chk("arst_status", bus_if.readdata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      clear_log();
      wr(4'd0, 32'h2);
      wait_idle(3000, "post_rst_timeout");
      chk("post_rst_frames", q_low.size(), 32'd9);
      rd(4'd13, d); chk("post_rst_result5", d, 32'h8000_0105);
      rd(4'd1, d); chk("post_rst_status", d, 32'h0000_0102);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/garduino_adc_spi_reader.md
Name: garduino_adc_spi_reader

Overview:
- Avalon-MM slave that runs the serial ADC (ADC128S022-class: 8 channels, 12 bits, 16-SCLK frames) in hardware and holds the latest conversion per channel in readable registers.
- It is the read side of the ADC path. The host stops bit-banging control lines and reads finished results instead.
- Sits on the Nios system bus next to the existing PIO peripherals and drives the ADC pins directly.

Parameters:
- CLK_DIV, 25: clk cycles per SCLK half-period (50 MHz gives 1 MHz SCLK); legal range 2..255.
- NUM_CH, 8: channels scanned per sweep, 0..NUM_CH-1; legal range 1..8.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  4  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  combinational read mux of address
- adc_cs_n  out  1  ADC chip select, active low
- adc_sclk  out  1  ADC serial clock, idles high
- adc_din  out  1  ADC channel-address serial input
- adc_dout  in  1  ADC serial data output (synchronised internally with 2 flops)

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: adc_cs_n=1, adc_sclk=1, adc_din=0, all registers 0, FSM in IDLE.
- A write occurs when chipselect && !write_n.
- readdata is combinational from address; unmapped addresses read 0.
- Register map:
  - addr 0 CTRL (R/W):
    - bit0 CONT: loop sweeps continuously.
    - bit1 START: write 1 launches one sweep; self-clears; reads 0.
    - bit2 IRQ_EN: stored always; used only with ADC_IRQ_EN.
  - addr 1 STATUS (R):
    - bit0 BUSY.
    - bit1 DONE: sticky, set when a sweep completes; write 1 to addr 1 bit1 clears it.
    - bits[15:8] SWEEP_CNT: 8-bit count of completed sweeps, wraps 255 to 0.
  - addr 8+n RESULT[n] (R), for n < NUM_CH:
    - bits[11:0] latest code.
    - bit31 VALID: set on first store, cleared only by reset.
- A sweep starts from IDLE when START is written or CONT=1.
- START written while BUSY is ignored.
- Clearing CONT mid-sweep finishes the current sweep, then the block stops.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
  - IDLE -> SETUP: adc_cs_n falls; frame index k=0.
  - SETUP: lasts CLK_DIV cycles, then SHIFT.
  - SHIFT: 32 half-periods with a half-period counter and a bit counter 15..0.
    - adc_sclk falls at the start of each bit.
    - adc_din is updated on each falling edge. Frame bits [13:11] carry the channel address (k mod NUM_CH); all other bits are 0.
    - adc_dout is sampled into a 16-bit shift register on each rising edge.
  - HOLD: lasts CLK_DIV cycles with adc_sclk high; then adc_cs_n=1.
  - GAP: lasts CLK_DIV cycles with adc_cs_n high.
    - If k < NUM_CH: k++, go to SETUP.
    - Else: set DONE, increment SWEEP_CNT; go to SETUP with k=0 if CONT, otherwise IDLE.
- Pipeline rule: the ADC returns the channel addressed in the previous frame.
  - Each sweep runs NUM_CH+1 frames.
  - The frame-0 result is discarded.
  - At the end of frame k >= 1, the shift register bits[11:0] are written to RESULT[k-1].
  - Bits [15:12] of the shift register are ignored.
- A result register updates in the cycle HOLD is entered, so the host never sees a partial value.
- Simultaneous DONE set and host clear of DONE in the same cycle: set wins.
- BUSY = (state != IDLE).
- Frame length: (1+32+1+1)*CLK_DIV clk cycles.
- Reset asserted mid-frame: all outputs return to reset values immediately; stored results are lost.

Optional Feature:
- Macro: ADC_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit), registered, reset 0.
  - irq = DONE && CTRL.IRQ_EN; it deasserts the cycle after DONE is cleared.
- When undefined: no irq port. CTRL bit2 still reads back what was written but has no effect.

Test Plan:
- ADC model returns 0x100+addr for each channel. Write CTRL=0x2 with NUM_CH=8, CLK_DIV=4 -> exactly 9 cs_n low pulses, each 128 clk plus setup/hold; RESULT[0..7] = 0x80000100..0x80000107; DONE=1; SWEEP_CNT=1; BUSY=0.
- Capture adc_din on rising adc_sclk -> frame k carries address k mod 8 in bits[13:11] (frame 8 carries 0); adc_sclk idles high; 16 rising edges per frame.
- Write CTRL=0x1, let 3 sweeps run, then write CTRL=0 -> SWEEP_CNT=3 or 4, never a partial sweep; after the last frame, BUSY=0 and cs_n=1.
- Write START while BUSY -> no restart and frame count unchanged. Write 0x2 to addr 1 in the same cycle DONE sets -> DONE stays 1.
- Assert reset_n low in the middle of frame 3 -> cs_n=1, sclk=1, all RESULT=0 asynchronously. A new START then gives a clean 9-frame sweep.
- ADC_IRQ_EN defined: CTRL=0x6 -> irq rises 1 cycle after DONE; write 2 to addr 1 -> irq falls the next cycle. With CTRL=0x2, irq stays 0.
